// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: next-PC select codes, fetch FSM
// states and the machine word width.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_JR     = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC generator: sequential, branch, jump and jr targets.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc_i,
  input  logic [1:0]        pc_src_i,
  input  logic              branch_taken_i,
  input  logic [15:0]       imm16_i,
  input  logic [25:0]       jtarget_i,
  input  logic [WORD_W-1:0] jr_addr_i,
  output logic [WORD_W-1:0] pc_plus4_o,
  output logic [WORD_W-1:0] next_pc_o
);

  logic [WORD_W-1:0] br_offset;

  assign pc_plus4_o = pc_i + 32'd4;
  // Word offset sign-extended then scaled to bytes.
  assign br_offset  = {{14{imm16_i[15]}}, imm16_i, 2'b00};

  always_comb begin
    next_pc_o = pc_plus4_o;
    unique case (pc_src_i)
      PC_SEQ:    next_pc_o = pc_plus4_o;
      PC_BRANCH: next_pc_o = branch_taken_i ? (pc_plus4_o + br_offset) : pc_plus4_o;
      PC_JUMP:   next_pc_o = {pc_plus4_o[31:28], jtarget_i, 2'b00};
      PC_JR:     next_pc_o = {jr_addr_i[31:2], 2'b00};
      default:   next_pc_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register, run/halt fetch FSM with self-loop detection, and retired /
// taken-branch counters for the single-cycle MIPS core.
module pc_fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BCNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [1:0]        pc_src,
  input  logic              branch_taken,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jtarget,
  input  logic [WORD_W-1:0] jr_addr,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              halted,
  output logic [31:0]       retired_cnt,
  output logic [BCNT_W-1:0] branch_cnt
);

  // state | meaning
  // RUN   | fetching; PC advances on every unstalled cycle
  // HALT  | self-loop retired; PC and counters frozen until reset

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [31:0]       retired_q, retired_d;
  logic [BCNT_W-1:0] branch_q, branch_d;
  logic [WORD_W-1:0] next_pc;
  logic              advance;

  pc_target_calc u_target (
    .pc_i           (pc_q),
    .pc_src_i       (pc_src),
    .branch_taken_i (branch_taken),
    .imm16_i        (imm16),
    .jtarget_i      (jtarget),
    .jr_addr_i      (jr_addr),
    .pc_plus4_o     (pc_plus4),
    .next_pc_o      (next_pc)
  );

  assign advance = (state_q == RUN) && !stall;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    branch_d  = branch_q;
    if (advance) begin
      pc_d      = next_pc;
      retired_d = retired_q + 32'd1;
      if (pc_src == PC_BRANCH && branch_taken && branch_q != {BCNT_W{1'b1}})
        branch_d = branch_q + 1'b1;
      // The instruction that loops onto itself is retired before halting.
      if (next_pc == pc_q)
        state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      branch_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      branch_q  <= branch_d;
    end
  end

  assign pc          = pc_q;
  assign halted      = (state_q == HALT);
  assign retired_cnt = retired_q;
  assign branch_cnt  = branch_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Program-counter stage of the single-cycle MIPS core; sits directly upstream of the instruction memory.
- Holds the PC register and drives the instruction-memory Address.
- Computes next-PC for sequential, branch, jump and jr flow.
- Detects the end-of-program self-loop (for example `j Loop` to its own address) and halts fetch.
- Keeps retired-instruction and taken-branch counters for bench and debug visibility.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BCNT_W, 16, width of the taken-branch counter, which saturates.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and counters this cycle.
- pc_src  in  2  next-PC select: 00 SEQ, 01 BRANCH, 10 JUMP, 11 JR.
- branch_taken  in  1  branch condition result from the ALU compare, used only when pc_src=BRANCH.
- imm16  in  16  instruction[15:0], branch offset in words.
- jtarget  in  26  instruction[25:0].
- jr_addr  in  32  rs register value for jr/jalr.
- pc  out  32  current PC, wired to instruction-memory Address.
- pc_plus4  out  32  pc+4, combinational, for the jal/jalr link write.
- halted  out  1  registered, 1 once the self-loop has been detected.
- retired_cnt  out  32  instructions retired since reset.
- branch_cnt  out  BCNT_W  taken branches since reset.

Behaviour:
- Reset (asynchronous assert, takes effect immediately): pc=RESET_PC, halted=0, retired_cnt=0, branch_cnt=0, FSM=RUN.
- Reset release: the first rising edge after deassertion advances from RESET_PC per that cycle's inputs.
- Reset asserted mid-run or while HALT: all state returns to reset values immediately.
- Next-PC calculation (combinational, all arithmetic modulo 2^32, wrap-around silent):
  - SEQ: pc+4.
  - BRANCH: if branch_taken, pc+4 + (sign-extended imm16 << 2); otherwise pc+4.
  - JUMP: {pc_plus4[31:28], jtarget, 2'b00}.
  - JR: {jr_addr[31:2], 2'b00}. Misaligned low bits are forced to zero, with no exception.
- FSM has two states, RUN and HALT.
- RUN, stall=0:
  - pc <= next_pc.
  - retired_cnt += 1 (32-bit wrap).
  - branch_cnt += 1 if pc_src=BRANCH and branch_taken; saturates at all-ones.
- RUN, stall=1: pc, both counters and the FSM state hold.
- RUN -> HALT when stall=0 and next_pc == pc. This covers a jump to self, a taken branch with imm16=16'hFFFF, and jr to the current pc.
  - The halting instruction is counted in retired_cnt (and in branch_cnt if it is a taken branch).
  - halted=1 from the following cycle onward.
- HALT:
  - pc and counters are frozen; inputs, including stall, are ignored.
  - Exit is by reset only.
- Simultaneous stall and self-loop condition: stall wins, no transition; detection happens on the first unstalled cycle.
- Latency: pc changes one clock after the inputs are sampled. pc_plus4 and next_pc are zero-latency combinational.
- The instruction memory is combinational, so pc to Instruction has no extra cycle.

Decomposition:
- Shared package mips_pkg holds:
  - PC_SEQ / PC_BRANCH / PC_JUMP / PC_JR 2-bit constants.
  - The fetch_state_t enum {RUN, HALT}.
  - The width constant WORD_W=32.
- One combinational sub-module, pc_target_calc, computes pc_plus4 and next_pc from (pc, pc_src, branch_taken, imm16, jtarget, jr_addr).
- The FSM, PC register and counters stay in pc_fetch_sequencer.

Test Plan:
- Reset and sequential fetch: hold reset low, then release with pc_src=SEQ for 3 cycles. Expect pc = 0x0, then 0x4, 0x8, 0xC; retired_cnt=3; halted=0.
- Branch: pc=0x10, pc_src=BRANCH, imm16=0x0001.
  - branch_taken=1: next pc=0x18, branch_cnt increments.
  - Repeat with branch_taken=0: next pc=0x14, branch_cnt unchanged.
- Jump and halt: pc=0x2C, pc_src=JUMP, jtarget=26'd11 (target 0x2C).
  - halted=1 on the next cycle; pc stays 0x2C.
  - retired_cnt frozen for 10 further cycles even with stall toggling.
- JR alignment and wrap:
  - jr_addr=0x0000_1003: pc becomes 0x0000_1000.
  - Then pc=0xFFFF_FFFC with SEQ: pc becomes 0x0000_0000, no halt.
- Stall versus halt: at pc=0x2C with a JUMP to self, assert stall=1 for 2 cycles.
  - pc holds, halted=0, counters hold.
  - Release stall: halted=1 the next cycle.
- Async reset from HALT: assert reset between clock edges. pc=RESET_PC, halted=0 and counters=0 immediately, without waiting for a clock edge.
